// File: rtl/nios2_system_sysid_pkg.sv
// nios2_system_sysid_pkg: shared state encoding, slave addresses and default
// expected values for the system-ID checker.
package nios2_system_sysid_pkg;
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ID   = 3'd1,
        S_WAIT_ID = 3'd2,
        S_RD_TS   = 3'd3,
        S_WAIT_TS = 3'd4,
        S_CMP     = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd0;
    localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1619612925;
endpackage

// File: rtl/nios2_system_sysid_period_timer.sv
// nios2_system_sysid_period_timer: free-running counter that pulses o_wrap
// once every PERIOD_CYCLES cycles (used under SYSID_CHECK_PERIODIC_EN).
module nios2_system_sysid_period_timer #(
    parameter int PERIOD_CYCLES = 1000000
) (
    input  logic i_clock,
    input  logic i_reset,
    output logic o_wrap
);
    localparam int W = $clog2(PERIOD_CYCLES) + 1;

    logic [W-1:0] r_cnt;
    logic         w_last;

    assign w_last = r_cnt == W'(PERIOD_CYCLES - 1);
    assign o_wrap = w_last;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_cnt <= '0;
        else         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/nios2_system_sysid_checker.sv
// nios2_system_sysid_checker: Avalon-MM read master that fetches the sysid ID
// and timestamp words and flags a mismatch. Periodic rechecks: SYSID_CHECK_PERIODIC_EN.
module nios2_system_sysid_checker
    import nios2_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
    parameter int          READ_LATENCY       = 1,
    parameter bit          AUTO_START         = 1'b1,
    parameter int          PERIOD_CYCLES      = 1000000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    output logic        o_avm_address,
    output logic        o_avm_read,
    input  logic [31:0] i_avm_readdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_valid,
    output logic        o_id_ok,
    output logic        o_ts_ok,
    output logic        o_sysid_ok,
    output logic [31:0] o_id_value,
    output logic [31:0] o_ts_value,
    output logic [7:0]  o_mismatch_count
);
    localparam bit         NO_WAIT  = READ_LATENCY == 0;
    localparam logic [3:0] LAT_LAST = 4'(NO_WAIT ? 0 : READ_LATENCY - 1);

    state_t      r_state, w_next;
    logic [3:0]  r_lat;
    logic        r_auto, r_valid, r_id_ok, r_ts_ok, r_sysid_ok;
    logic [31:0] r_id_value, r_ts_value;
    logic [7:0]  r_count;
    logic        w_pending, w_go, w_enter, w_lat_last, w_cap_id, w_cap_ts, w_match;

`ifdef SYSID_CHECK_PERIODIC_EN
    logic w_wrap, r_pending;

    nios2_system_sysid_period_timer #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_timer (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .o_wrap (w_wrap)
    );

    // A wrap wins over the clear so a wrap while busy is never lost.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)      r_pending <= 1'b0;
        else if (w_wrap)  r_pending <= 1'b1;
        else if (w_enter) r_pending <= 1'b0;
    end
    assign w_pending = r_pending;
`else
    assign w_pending = 1'b0;
`endif

    assign w_go       = i_start | r_auto | w_pending;
    assign w_enter    = (r_state == S_IDLE) && w_go;
    assign w_lat_last = r_lat == LAT_LAST;
    assign w_cap_id   = NO_WAIT ? r_state == S_RD_ID : (r_state == S_WAIT_ID) && w_lat_last;
    assign w_cap_ts   = NO_WAIT ? r_state == S_RD_TS : (r_state == S_WAIT_TS) && w_lat_last;
    assign w_match    = (r_id_value == EXPECTED_ID) && (r_ts_value == EXPECTED_TIMESTAMP);

    always_comb begin
        w_next        = r_state;
        o_avm_read    = (r_state == S_RD_ID) || (r_state == S_RD_TS);
        o_avm_address = (r_state == S_RD_TS) || (r_state == S_WAIT_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
        o_busy        = r_state != S_IDLE;
        o_done        = r_state == S_DONE;
        case (r_state)
            S_IDLE:    w_next = w_go ? S_RD_ID : S_IDLE;
            S_RD_ID:   w_next = NO_WAIT ? S_RD_TS : S_WAIT_ID;
            S_WAIT_ID: w_next = w_lat_last ? S_RD_TS : S_WAIT_ID;
            S_RD_TS:   w_next = NO_WAIT ? S_CMP : S_WAIT_TS;
            S_WAIT_TS: w_next = w_lat_last ? S_CMP : S_WAIT_TS;
            S_CMP:     w_next = S_DONE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_lat      <= '0;
            r_auto     <= AUTO_START;
            r_valid    <= 1'b0;
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_sysid_ok <= 1'b0;
            r_id_value <= '0;
            r_ts_value <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_next;
            r_lat   <= (r_state == S_WAIT_ID || r_state == S_WAIT_TS) ? r_lat + 1'b1 : '0;
            r_auto  <= 1'b0;
            if (w_enter) begin
                r_valid    <= 1'b0;
                r_id_ok    <= 1'b0;
                r_ts_ok    <= 1'b0;
                r_sysid_ok <= 1'b0;
            end
            if (w_cap_id) r_id_value <= i_avm_readdata;
            if (w_cap_ts) r_ts_value <= i_avm_readdata;
            if (r_state == S_CMP) begin
                r_valid    <= 1'b1;
                r_id_ok    <= r_id_value == EXPECTED_ID;
                r_ts_ok    <= r_ts_value == EXPECTED_TIMESTAMP;
                r_sysid_ok <= w_match;
                if (!w_match && r_count != 8'hFF) r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_valid          = r_valid;
    assign o_id_ok          = r_id_ok;
    assign o_ts_ok          = r_ts_ok;
    assign o_sysid_ok       = r_sysid_ok;
    assign o_id_value       = r_id_value;
    assign o_ts_value       = r_ts_value;
    assign o_mismatch_count = r_count;
endmodule
